dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane.sv | 44 ++++
 rtl/dmem_ctrl.sv | 133 +++++++++++++
 tb/tb_dmem_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned DMEM_DEPTH_WORDS_DEF = 1024;
  localparam int unsigned DMEM_LATENCY_DEF     = 1;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store mask/shift and load extract/extend, alignment forced down.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [1:0]  off;
  logic [31:0] rsh;

  always_comb begin
    off       = '0;
    wmask     = '0;
    rdata_ext = '0;
    case (size)
      SZ_BYTE: begin
        off   = addr_lo;
        wmask = 4'b0001 << off;
      end
      SZ_HALF: begin
        off   = {addr_lo[1], 1'b0};
        wmask = 4'b0011 << off;
      end
      SZ_WORD: wmask = '1;
      default: ;
    endcase
    wdata_sh = wdata << {off, 3'b000};
    rsh      = rword >> {off, 3'b000};
    case (size)
      SZ_BYTE: rdata_ext = {{24{~is_unsigned & rsh[7]}}, rsh[7:0]};
      SZ_HALF: rdata_ext = {{16{~is_unsigned & rsh[15]}}, rsh[15:0]};
      SZ_WORD: rdata_ext = rsh;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: clear-on-reset, fixed-latency load/store with byte lanes.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning them.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = DMEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  state_e        state, state_n;
  logic [AW-1:0] clr_idx, clr_idx_n;
  logic [1:0]    wait_cnt, wait_cnt_n;
  logic          done_q, done_n;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [AW-1:0] widx;
  logic          out_of_range, misaligned, err, accept;
  logic [3:0]    wmask;
  logic [31:0]   wdata_sh, rdata_ext;

  assign widx         = req_addr[AW+1:2];
  assign out_of_range = |req_addr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign err    = out_of_range || (req_size == 2'b11) || misaligned;
  // Outputs are qualified with reset so they read 0 during the reset cycle itself.
  assign req_ready  = (state == ST_IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == ST_RESP) && !reset;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid ? err_q : 1'b0;
  assign init_done  = done_q && !reset;

  dmem_lane u_lane (
    .size        (req_size),
    .addr_lo     (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (mem[widx]),
    .wmask       (wmask),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (accept && req_we && !err) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wmask[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_idx  <= '0;
      wait_cnt <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      clr_idx  <= clr_idx_n;
      wait_cnt <= wait_cnt_n;
      done_q   <= done_n;
      if (accept) begin
        rdata_q <= (req_we || err) ? '0 : rdata_ext;
        err_q   <= err;
      end
    end
  end

  always_comb begin
    state_n    = state;
    clr_idx_n  = clr_idx;
    wait_cnt_n = wait_cnt;
    done_n     = done_q;
    case (state)
      ST_CLEAR: begin
        clr_idx_n = clr_idx + AW'(1);
        if (clr_idx == AW'(DEPTH_WORDS - 1)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = ST_RESP;
          end else begin
            state_n    = ST_WAIT;
            wait_cnt_n = 2'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_n = ST_RESP;
        else wait_cnt_n = wait_cnt - 2'd1;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: default instance (1024 words, latency 1) and a small latency-3 instance.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, init_done;
  logic [31:0] resp_rdata;

  logic        r1_valid, r1_we, r1_unsigned;
  logic [1:0]  r1_size;
  logic [31:0] r1_addr, r1_wdata;
  logic        r1_ready, r1_resp_valid, r1_err, r1_init_done;
  logic [31:0] r1_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl u0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .init_done    (init_done)
  );

  dmem_ctrl #(.DEPTH_WORDS(16), .LATENCY(3)) u1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (r1_valid),
    .req_ready    (r1_ready),
    .req_we       (r1_we),
    .req_size     (r1_size),
    .req_unsigned (r1_unsigned),
    .req_addr     (r1_addr),
    .req_wdata    (r1_wdata),
    .resp_valid   (r1_resp_valid),
    .resp_rdata   (r1_rdata),
    .resp_err     (r1_err),
    .init_done    (r1_init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One latency-1 transaction on u0; also checks the strobe drops with data/err zeroed.
  task automatic req0(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("u0_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("u0_resp_valid", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
    chk("u0_resp_drop", {resp_valid, resp_err, 30'd0} | resp_rdata, 32'd0);
  endtask

  // Counts edges after reset release until each instance reports init_done.
  task automatic count_clear(output int n0, output int n1, inout int pulses);
    n0 = 0;
    n1 = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (r1_resp_valid || resp_valid) pulses++;
      if (init_done && n0 == 0) n0 = c;
      if (r1_init_done && n1 == 0) n1 = c;
      if (n0 != 0 && n1 != 0) break;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          n0, n1, pulses;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_size = 2'b10; r1_unsigned = 1'b0;
    r1_addr = '0; r1_wdata = '0;
    pulses = 0;

    @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    count_clear(n0, n1, pulses);
    chk("clear_cycles_1024", n0, 1024);
    chk("clear_cycles_16", n1, 16);

    req0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    chk("ld_after_clear", rd, 32'h0);
    chk("ld_after_clear_err", 32'(er), 32'd0);

    req0(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, rd, er);
    chk("st_word_rdata", rd, 32'h0);
    chk("st_word_err", 32'(er), 32'd0);
    req0(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rd, er);
    chk("ld_byte_signed", rd, 32'hFFFFFF80);
    req0(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rd, er);
    chk("ld_byte_unsigned", rd, 32'h00000080);
    req0(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, er);
    chk("ld_half_signed_lo", rd, 32'h00007F01);
    req0(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er);
    chk("ld_half_signed_hi", rd, 32'hFFFF80FF);
    req0(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er);
    chk("ld_half_unsigned_hi", rd, 32'h000080FF);

    req0(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er);
    req0(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, rd, er);
    req0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("st_byte_merge", rd, 32'h1122AB44);

    req0(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, rd, er);
    req0(1'b1, 2'b10, 1'b0, 32'h00001000, 32'hDEADBEEF, rd, er);
    chk("oor_store_err", 32'(er), 32'd1);
    chk("oor_store_rdata", rd, 32'h0);
    req0(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er);
    chk("oor_no_write", rd, 32'hCAFEF00D);
    req0(1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, rd, er);
    chk("oor_load_err", 32'(er), 32'd1);
    req0(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er);
    chk("size11_err", 32'(er), 32'd1);
    chk("size11_rdata", rd, 32'h0);

    req0(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, er);
    req0(1'b1, 2'b01, 1'b0, 32'h21, 32'h00007777, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign_half_st_err", 32'(er), 32'd1);
    req0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("misalign_no_write", rd, 32'h1122AB44);
`else
    chk("misalign_half_st_err", 32'(er), 32'd0);
    req0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("misalign_half_forced", rd, 32'h11227777);
`endif
    // word load @0x22 issued above: redo to capture its result here
    req0(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign_word_err", 32'(er), 32'd1);
    chk("misalign_word_rdata", rd, 32'h0);
`else
    chk("misalign_word_err", 32'(er), 32'd0);
    chk("misalign_word_rdata", rd, 32'h11227777);
`endif

    // Latency-3 instance: store then load, strobe position and ready checked per cycle.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk("u1_ready_idle", 32'(r1_ready), 32'd1);
      r1_valid = 1'b1; r1_we = (t == 0); r1_size = 2'b10; r1_unsigned = 1'b0;
      r1_addr = 32'h4; r1_wdata = 32'h5A5AC3C3;
      @(posedge clk);
      #1;
      r1_valid = 1'b0;
      chk("u1_k0_valid", 32'(r1_resp_valid), 32'd0);
      chk("u1_k0_ready", 32'(r1_ready), 32'd0);
      chk("u1_k0_rdata_zero", r1_rdata, 32'h0);
      @(posedge clk);
      #1;
      chk("u1_k1_valid", 32'(r1_resp_valid), 32'd0);
      chk("u1_k1_ready", 32'(r1_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("u1_k2_valid", 32'(r1_resp_valid), 32'd1);
      chk("u1_k2_ready", 32'(r1_ready), 32'd0);
      chk("u1_k2_rdata", r1_rdata, (t == 0) ? 32'h0 : 32'h5A5AC3C3);
      @(posedge clk);
      #1;
      chk("u1_k3_valid", 32'(r1_resp_valid), 32'd0);
      chk("u1_k3_ready", 32'(r1_ready), 32'd1);
    end

    // Reset while u1 is in WAIT: response dropped, both instances re-clear.
    @(negedge clk);
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 32'h4;
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("wait_rst_valid", 32'(r1_resp_valid), 32'd0);
    chk("wait_rst_init", 32'(r1_init_done), 32'd0);
    repeat (100) begin
      @(posedge clk);
      #1;
      if (r1_resp_valid || resp_valid) pulses++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midclear_rst_init", 32'(init_done), 32'd0);
    count_clear(n0, n1, pulses);
    chk("reclear_cycles_1024", n0, 1024);
    chk("reclear_cycles_16", n1, 16);
    chk("dropped_resp_pulses", pulses, 0);
    req0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("reclear_word20", rd, 32'h0);
    req0(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er);
    chk("reclear_word0", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
